// File: rtl/instr_fetch.sv
// Program counter / instruction fetch: IDLE/RUN/DONE sequencing, 8-entry branch-target LUT,
// saturating RUN cycle counter. Define RELATIVE_BRANCH_EN for PC-relative LUT targets.
module instr_fetch #(
  parameter int unsigned PW = 10,
  parameter int unsigned CW = 16
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_stall,
  input  logic [2:0]    i_pc_targ,
  input  logic [1:0]    i_branch_en,
  input  logic          i_jump,
  input  logic          i_ack,
  input  logic          i_zero,
  input  logic          i_neg,
  input  logic          i_lut_wr_en,
  input  logic [2:0]    i_lut_wr_addr,
  input  logic [PW-1:0] i_lut_wr_data,
  output logic [PW-1:0] o_prog_ctr,
  output logic          o_running,
  output logic          o_done,
  output logic [CW-1:0] o_cycle_count
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        r_state;
  logic [PW-1:0] r_pc;
  logic [CW-1:0] r_cnt;
  logic          r_running;
  logic          r_done;
  logic [PW-1:0] r_lut [8];

  logic [PW-1:0] w_lut_entry;
  logic [PW-1:0] w_target;
  logic          w_taken;
  logic [PW-1:0] w_next_pc;
  logic          w_cnt_sat;

  assign w_lut_entry = r_lut[i_pc_targ];

`ifdef RELATIVE_BRANCH_EN
  // Two's-complement entry added with natural PW-bit wrap in both directions.
  assign w_target = r_pc + w_lut_entry;
`else
  assign w_target = w_lut_entry;
`endif

  always_comb begin
    w_taken = 1'b0;
    unique case (i_branch_en)
      2'b00:   w_taken = 1'b0;
      2'b01:   w_taken = i_zero;
      2'b10:   w_taken = ~i_zero;
      2'b11:   w_taken = i_neg;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_next_pc = r_pc + PW'(1);
    if (i_jump || w_taken) begin
      w_next_pc = w_target;
    end
  end

  assign w_cnt_sat = &r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_pc      <= '0;
      r_cnt     <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_lut[i] <= '0;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_lut_wr_en) begin
            r_lut[i_lut_wr_addr] <= i_lut_wr_data;
          end
          if (i_start) begin
            r_state   <= StRun;
            r_pc      <= '0;
            r_cnt     <= '0;
            r_running <= 1'b1;
            r_done    <= 1'b0;
          end
        end
        StRun: begin
          // Stalled cycles still count toward the benchmark total.
          if (!w_cnt_sat) begin
            r_cnt <= r_cnt + CW'(1);
          end
          if (!i_stall) begin
            if (i_ack) begin
              r_state   <= StDone;
              r_running <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_pc <= w_next_pc;
            end
          end
        end
        StDone: begin
          if (i_start) begin
            r_state   <= StRun;
            r_pc      <= '0;
            r_cnt     <= '0;
            r_running <= 1'b1;
            r_done    <= 1'b0;
          end
        end
        default: begin
          r_state   <= StIdle;
          r_pc      <= '0;
          r_running <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  assign o_prog_ctr    = r_pc;
  assign o_running     = r_running;
  assign o_done        = r_done;
  assign o_cycle_count = r_cnt;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed stimulus, spec-level reference model checked every cycle,
// plus literal expectations. Follows RELATIVE_BRANCH_EN like the design.
module tb_instr_fetch;

  localparam int unsigned PW = 10;
  localparam int unsigned CW = 4;
  localparam int PMOD = 1 << PW;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset, start, stall, jump, ack, zero, neg, lut_wr_en;
  logic [2:0]    pc_targ, lut_wr_addr;
  logic [1:0]    branch_en;
  logic [PW-1:0] lut_wr_data;
  logic [PW-1:0] prog_ctr;
  logic          running, done;
  logic [CW-1:0] cycle_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference state: 0 idle, 1 run, 2 done.
  int m_st, m_pc, m_cnt;
  int m_lut [8];

  always #5 clk = ~clk;

  instr_fetch #(.PW(PW), .CW(CW)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_start       (start),
    .i_stall       (stall),
    .i_pc_targ     (pc_targ),
    .i_branch_en   (branch_en),
    .i_jump        (jump),
    .i_ack         (ack),
    .i_zero        (zero),
    .i_neg         (neg),
    .i_lut_wr_en   (lut_wr_en),
    .i_lut_wr_addr (lut_wr_addr),
    .i_lut_wr_data (lut_wr_data),
    .o_prog_ctr    (prog_ctr),
    .o_running     (running),
    .o_done        (done),
    .o_cycle_count (cycle_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    int st, pc, cnt, tgt;
    bit taken;
    st = m_st; pc = m_pc; cnt = m_cnt;
`ifdef RELATIVE_BRANCH_EN
    tgt = (m_pc + m_lut[pc_targ]) % PMOD;
`else
    tgt = m_lut[pc_targ];
`endif
    taken = (branch_en == 2'b01 && zero) || (branch_en == 2'b10 && !zero) ||
            (branch_en == 2'b11 && neg);
    if (reset) begin
      st = 0; pc = 0; cnt = 0;
      for (int i = 0; i < 8; i++) m_lut[i] <= 0;
    end else if (st == 0) begin
      if (lut_wr_en) m_lut[lut_wr_addr] <= int'(lut_wr_data);
      if (start) begin st = 1; pc = 0; cnt = 0; end
    end else if (st == 1) begin
      cnt = (cnt < CMAX) ? cnt + 1 : CMAX;
      if (!stall) begin
        if (ack) st = 2;
        else if (jump || taken) pc = tgt;
        else pc = (pc + 1) % PMOD;
      end
    end else if (start) begin
      st = 1; pc = 0; cnt = 0;
    end
    m_st <= st; m_pc <= pc; m_cnt <= cnt;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model prog_ctr", int'(prog_ctr), m_pc);
      chk("model running", int'(running), int'(m_st == 1));
      chk("model done", int'(done), int'(m_st == 2));
      chk("model cycle_count", int'(cycle_count), m_cnt);
    end
  end

  task automatic clear_in();
    reset = 1'b0; start = 1'b0; stall = 1'b0; jump = 1'b0; ack = 1'b0;
    zero = 1'b0; neg = 1'b0; lut_wr_en = 1'b0; pc_targ = 3'd0; lut_wr_addr = 3'd0;
    branch_en = 2'b00; lut_wr_data = '0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic lut_wr(input logic [2:0] a, input logic [PW-1:0] d);
    lut_wr_en = 1'b1; lut_wr_addr = a; lut_wr_data = d;
    tick();
    lut_wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_in();
    reset = 1'b1; start = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    clear_in();
    tick();
    chk("reset prog_ctr", int'(prog_ctr), 0);
    chk("reset running", int'(running), 0);
    chk("reset done", int'(done), 0);
    chk("reset cycle_count", int'(cycle_count), 0);

    // IDLE: LUT loads; redirect inputs must not move the PC.
`ifdef RELATIVE_BRANCH_EN
    lut_wr(3'd3, 10'h3FE);
`else
    lut_wr(3'd3, 10'h040);
`endif
    lut_wr(3'd1, 10'h100);
    jump = 1'b1; ack = 1'b1; pc_targ = 3'd3;
    lut_wr(3'd5, 10'h3FF);
    chk("idle pc hold", int'(prog_ctr), 0);
    clear_in();

    start = 1'b1;
    tick();
    chk("start running", int'(running), 1);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);  // start ignored while running
      tick();
    end
    start = 1'b0;
    chk("seq pc", int'(prog_ctr), 5);
    chk("seq count", int'(cycle_count), 5);

    pc_targ = 3'd3; jump = 1'b1;
    tick();
`ifdef RELATIVE_BRANCH_EN
    chk("jump pc", int'(prog_ctr), 3);
`else
    chk("jump pc", int'(prog_ctr), 'h040);
`endif
    jump = 1'b0;

    branch_en = 2'b01; zero = 1'b0; pc_targ = 3'd1;
    tick();
`ifdef RELATIVE_BRANCH_EN
    chk("beq not taken", int'(prog_ctr), 4);
`else
    chk("beq not taken", int'(prog_ctr), 'h041);
`endif
    zero = 1'b1;
    tick();
`ifdef RELATIVE_BRANCH_EN
    chk("beq taken", int'(prog_ctr), 'h104);
`else
    chk("beq taken", int'(prog_ctr), 'h100);
`endif
    branch_en = 2'b10; zero = 1'b0; pc_targ = 3'd3; tick();
    branch_en = 2'b11; neg = 1'b1; pc_targ = 3'd1; tick();
`ifdef RELATIVE_BRANCH_EN
    chk("bneg taken", int'(prog_ctr), 'h202);
`else
    chk("bneg taken", int'(prog_ctr), 'h100);
`endif
    neg = 1'b0; tick();
    branch_en = 2'b10; zero = 1'b1; tick();
    branch_en = 2'b00; neg = 1'b1; tick();
    clear_in();

    // Stall with a pending jump: PC frozen, counter still runs into saturation.
    stall = 1'b1; jump = 1'b1; pc_targ = 3'd3;
    for (int i = 0; i < 3; i++) tick();
    chk("stall count", int'(cycle_count), 15);
    stall = 1'b0;
    tick();
    chk("sat count", int'(cycle_count), CMAX);
    jump = 1'b0; tick(); tick();

    pc_targ = 3'd5; jump = 1'b1; tick();
    jump = 1'b0; tick();
`ifndef RELATIVE_BRANCH_EN
    chk("pc wrap", int'(prog_ctr), 0);
`endif

    ack = 1'b1; stall = 1'b1; tick();
    chk("stalled ack", int'(running), 1);
    stall = 1'b0; jump = 1'b1; pc_targ = 3'd3; tick();
    chk("ack done", int'(done), 1);
    chk("ack running", int'(running), 0);
    clear_in();

    // DONE: frozen, LUT writes and redirects ignored.
    lut_wr_en = 1'b1; lut_wr_addr = 3'd3; lut_wr_data = 10'h123; jump = 1'b1;
    tick(); tick();
    clear_in();
    start = 1'b1; tick();
    chk("restart count", int'(cycle_count), 0);
    start = 1'b0; pc_targ = 3'd3; jump = 1'b1; tick();
`ifdef RELATIVE_BRANCH_EN
    chk("lut retained", int'(prog_ctr), 'h3FE);
`else
    chk("lut retained", int'(prog_ctr), 'h040);
`endif
    clear_in();
    tick(); tick();

    // Reset beats Start; LUT cleared afterwards.
    reset = 1'b1; start = 1'b1; tick();
    chk("mid reset running", int'(running), 0);
    chk("mid reset count", int'(cycle_count), 0);
    reset = 1'b0; tick();
    start = 1'b0; tick();
    pc_targ = 3'd3; jump = 1'b1; tick();
`ifdef RELATIVE_BRANCH_EN
    chk("lut cleared", int'(prog_ctr), 1);
`else
    chk("lut cleared", int'(prog_ctr), 0);
`endif
    clear_in();
    ack = 1'b1; tick();
    clear_in(); tick();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
